// File: rtl/debug_pkg.sv
// Shared types and constants for the debug unit.
//   state_e    : FSM state encoding
//   snap_t     : 96-bit dump record {cycle count, pc, instruction}, MSB sent first
//   *_DEF      : default command bytes and halt word
//   DUMP_BYTES : bytes per dump
`timescale 1ns/1ps
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TX
  } state_e;

  localparam logic [7:0]  CMD_STEP_DEF  = 8'h73;  // 's'
  localparam logic [7:0]  CMD_RUN_DEF   = 8'h63;  // 'c'
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam int          DUMP_BYTES    = 12;
  localparam int          IDX_W         = 4;

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] pc;
    logic [31:0] instr;
  } snap_t;

endpackage

// File: rtl/dbg_snapshot_mux.sv
// Snapshot register and byte selector for the debug dump.
//   clk, rst_n : clock, async active-low reset
//   load_i     : capture snap_i and rewind the byte index to 0
//   adv_i      : step to the next byte (saturates on the last byte)
//   snap_i     : record to capture
//   byte_o     : currently selected byte, MSB of the record first
//   last_o     : index points at the final byte
`timescale 1ns/1ps
module dbg_snapshot_mux import debug_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       adv_i,
  input  snap_t      snap_i,
  output logic [7:0] byte_o,
  output logic       last_o
);

  snap_t                          snap_q;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [DUMP_BYTES-1:0][7:0]     bytes;

  // Element DUMP_BYTES-1 holds cnt[31:24], element 0 holds instr[7:0].
  assign bytes  = snap_q;
  assign last_o = (idx_q == IDX_W'(DUMP_BYTES-1));
  assign byte_o = bytes[IDX_W'(DUMP_BYTES-1) - idx_q];

  always_comb begin
    idx_d = idx_q;
    if (load_i)               idx_d = '0;
    else if (adv_i && !last_o) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      idx_q  <= '0;
    end else begin
      idx_q <= idx_d;
      if (load_i) snap_q <= snap_i;
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Serial-driven pipeline debug unit: single-step / run-to-halt, then dump
// {cycle count, pc, instruction} as 12 bytes over a byte transmitter.
//   clk, reset     : clock, async active-low reset
//   rx_data/rx_done: received command byte + strobe
//   tx_done        : transmitter finished current byte
//   pc/instruction : IF-stage pc and fetched instruction
//   ena            : pipeline enable
//   tx_start/tx_data: transmit request + byte (held until tx_done)
//   busy           : FSM not idle
// All outputs are registered.
`timescale 1ns/1ps
module debug_unit import debug_pkg::*; #(
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter logic [7:0]  CMD_STEP  = CMD_STEP_DEF,
  parameter logic [7:0]  CMD_RUN   = CMD_RUN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        tx_done,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic        ena,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        ena_q, ena_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        snap_load, snap_adv, snap_last;
  logic [7:0]  snap_byte;
  snap_t       snap_in;

  // The pipeline state seen on the last enabled cycle is what gets dumped,
  // so inputs may wander freely once ena drops.
  always_comb begin
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (ena_q) begin
      cnt_d   = cnt_q + 32'd1;
      pc_d    = pc;
      instr_d = instruction;
    end
  end

  assign snap_in.cnt   = cnt_q;
  assign snap_in.pc    = pc_q;
  assign snap_in.instr = instr_q;

  always_comb begin
    state_d    = state_q;
    ena_d      = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    snap_load  = 1'b0;
    snap_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          if (rx_data == CMD_RUN) begin
            state_d = ST_RUN;
            ena_d   = 1'b1;
          end else if (rx_data == CMD_STEP) begin
            state_d = ST_STEP;
            ena_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // ena is always high here; the halting cycle itself is counted.
        if (instruction == HALT_WORD) state_d = ST_LOAD;
        else                          ena_d   = 1'b1;
      end
      ST_STEP: state_d = ST_LOAD;
      ST_LOAD: begin
        snap_load = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        tx_data_d  = snap_byte;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          if (snap_last) state_d = ST_IDLE;
          else begin
            snap_adv = 1'b1;
            state_d  = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ena_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      ena_q      <= ena_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  dbg_snapshot_mux u_snap (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (snap_load),
    .adv_i  (snap_adv),
    .snap_i (snap_in),
    .byte_o (snap_byte),
    .last_o (snap_last)
  );

  assign ena      = ena_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_debug_unit.sv
`timescale 1ns/1ps
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] instruction = 32'h0;
  logic        ena, tx_start, busy;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  debug_unit dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_done(tx_done), .pc(pc), .instruction(instruction),
    .ena(ena), .tx_start(tx_start), .tx_data(tx_data), .busy(busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Monitor state (written only by the monitor process)
  int         ena_cnt = 0, txd_cnt = 0, stab_viol = 0;
  logic [7:0] tx_log[$];
  logic [7:0] held;
  logic       inflight = 1'b0;

  int tx_delay = 3;

  initial forever begin
    @(posedge clk); #1;
    if (!reset) inflight = 1'b0;
    else begin
      if (ena) ena_cnt++;
      if (tx_done) txd_cnt++;
      if (tx_start) begin
        tx_log.push_back(tx_data);
        held = tx_data;
        inflight = 1'b1;
      end else if (inflight && tx_data !== held) stab_viol++;
      if (tx_done) inflight = 1'b0;
    end
  end

  // Transmitter model: acknowledge each tx_start after tx_delay cycles
  initial forever begin
    @(negedge clk);
    if (tx_start && reset) begin
      repeat (tx_delay) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      if (!busy) ok = 1;
    end
    if (!ok) timeout(nm);
  endtask

  task automatic wait_txs(input string nm, input int target, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      if (tx_log.size() >= target) ok = 1;
    end
    if (!ok) timeout(nm);
  endtask

  task automatic check_dump(input string nm, input int base, input logic [95:0] exp);
    logic [7:0] got;
    for (int i = 0; i < 12; i++) begin
      got = (base + i < tx_log.size()) ? tx_log[base+i] : 8'hxx;
      check($sformatf("%s byte%0d", nm, i), {24'h0, got}, {24'h0, exp[95-8*i -: 8]});
    end
  endtask

  typedef struct {
    bit          rst;
    logic [7:0]  cmd;
    int          halt_at;   // enabled cycle carrying pc/instr below
    logic [31:0] pc;
    logic [31:0] instr;
    int          exp_ena;
    logic [95:0] exp_dump;
  } vec_t;

  vec_t vt[6];

  int e0, t0, s0, d0, t1, busy_hi;

  initial begin
    vt[0] = '{1, 8'h73, 1, 32'h0000_0004, 32'h2008_0005, 1, 96'h00000001_00000004_20080005};
    vt[1] = '{1, 8'h63, 5, 32'h0000_0014, 32'hFFFF_FFFF, 5, 96'h00000005_00000014_FFFFFFFF};
    vt[2] = '{0, 8'h73, 1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 96'h00000006_00000100_DEADBEEF};
    vt[3] = '{0, 8'h63, 1, 32'h0000_0200, 32'hFFFF_FFFF, 1, 96'h00000007_00000200_FFFFFFFF};
    vt[4] = '{0, 8'h73, 1, 32'h0000_0300, 32'hFFFF_FFFF, 1, 96'h00000008_00000300_FFFFFFFF};
    vt[5] = '{0, 8'h63, 3, 32'hA5A5_0001, 32'hFFFF_FFFF, 3, 96'h0000000B_A5A50001_FFFFFFFF};

    // Reset state
    #12;
    check("rst ena", {31'h0, ena}, 32'h0);
    check("rst tx_start", {31'h0, tx_start}, 32'h0);
    check("rst tx_data", {24'h0, tx_data}, 32'h0);
    check("rst busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post-rst busy", {31'h0, busy}, 32'h0);

    // Table of step/run commands
    for (int v = 0; v < 6; v++) begin
      if (vt[v].rst) do_reset();
      pc = 32'h0000_0008;
      instruction = 32'h0000_0013;
      e0 = ena_cnt; t0 = tx_log.size();
      send_byte(vt[v].cmd);
      repeat (vt[v].halt_at - 1) @(negedge clk);
      pc = vt[v].pc;
      instruction = vt[v].instr;
      wait_txs($sformatf("v%0d first tx", v), t0 + 1, 200);
      @(negedge clk);
      pc = 32'h5555_5555;
      instruction = 32'hAAAA_AAAA;
      wait_idle($sformatf("v%0d idle", v), 2000);
      check($sformatf("v%0d ena cycles", v), 32'(ena_cnt - e0), 32'(vt[v].exp_ena));
      check($sformatf("v%0d tx count", v), 32'(tx_log.size() - t0), 32'd12);
      check_dump($sformatf("v%0d", v), t0, vt[v].exp_dump);
    end

    // Unknown command in IDLE is ignored
    e0 = ena_cnt; t0 = tx_log.size(); busy_hi = 0;
    send_byte(8'h78);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    check("x ena", 32'(ena_cnt - e0), 32'd0);
    check("x tx_start", 32'(tx_log.size() - t0), 32'd0);
    check("x busy", 32'(busy_hi), 32'd0);

    // Command during WAIT_TX with slow transmitter: ignored, data held
    tx_delay = 50;
    e0 = ena_cnt; t0 = tx_log.size(); s0 = stab_viol;
    pc = 32'h0000_0040; instruction = 32'h1234_5678;
    send_byte(8'h73);
    wait_txs("slow first tx", t0 + 1, 200);
    send_byte(8'h73);
    repeat (10) @(negedge clk);
    send_byte(8'h63);
    wait_idle("slow idle", 5000);
    repeat (100) @(negedge clk);
    check("slow tx count", 32'(tx_log.size() - t0), 32'd12);
    check("slow ena cycles", 32'(ena_cnt - e0), 32'd1);
    check("slow tx_data stable", 32'(stab_viol - s0), 32'd0);
    check("slow busy", {31'h0, busy}, 32'h0);
    check_dump("slow", t0, 96'h0000000C_00000040_12345678);
    tx_delay = 3;

    // Reset after the third tx_done of a dump
    d0 = txd_cnt; t0 = tx_log.size();
    send_byte(8'h73);
    begin
      bit ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(posedge clk); #2;
        if (txd_cnt >= d0 + 3) ok = 1;
      end
      if (!ok) timeout("abort 3rd tx_done");
    end
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort ena", {31'h0, ena}, 32'h0);
    check("abort tx_start", {31'h0, tx_start}, 32'h0);
    check("abort tx_data", {24'h0, tx_data}, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("abort no more tx", 32'(tx_log.size() - t0), 32'd3);
    t0 = tx_log.size();
    pc = 32'h0000_0004; instruction = 32'h2008_0005;
    send_byte(8'h73);
    wait_idle("abort redo idle", 2000);
    check("abort redo tx count", 32'(tx_log.size() - t0), 32'd12);
    check_dump("abort redo", t0, 96'h00000001_00000004_20080005);

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cnt_q;
    t0 = tx_log.size();
    pc = 32'h0000_0080; instruction = 32'h0BAD_F00D;
    send_byte(8'h73);
    wait_idle("wrap idle", 2000);
    check_dump("wrap", t0, 96'h00000000_00000080_0BADF00D);
    t0 = tx_log.size();
    send_byte(8'h73);
    wait_idle("wrap2 idle", 2000);
    check_dump("wrap2", t0, 96'h00000001_00000080_0BADF00D);

    check("tx_data stable overall", 32'(stab_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global: simulation time limit reached");
    $fatal(1);
  end

endmodule
